// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register offsets, STATUS bit positions and the serial
// state encoding shared by the UART peripheral and its sub-blocks.
package uart_mmio_pkg;

  // Byte offsets inside the 16-byte register window (Address[3:0]).
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  // STATUS register bit positions.
  localparam int ST_TX_FULL = 0;
  localparam int ST_TX_IDLE = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_TX_OVF = 3;
  localparam int ST_RX_OVR = 4;
  localparam int ST_RX_FERR = 5;

  // Frame phase, used by both the transmitter and the receiver.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: CPU MEM-stage load/store port as seen by a memory-mapped
// responder. The CPU side drives the request, the peripheral answers with
// combinational read data and an address hit.
interface uart_mmio_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        Hit;

  modport master (
    output MemRead, MemWrite, Address, Write_data,
    input  Read_data, Hit
  );

  modport slave (
    input  MemRead, MemWrite, Address, Write_data,
    output Read_data, Hit
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO holding bytes
// waiting for the transmitter. A push while full and a pop while empty
// are ignored; DEPTH must be a power of two.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the count before the edge, so a pop on the same
  // edge never makes room for a push.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array write port.
  // NOTE: the data array has no reset; only pointers and count are cleared,
  // which is enough to make the contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: state is updated with non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART on the CPU data-memory port.
// TXDATA stores feed a byte FIFO drained by the transmit FSM; STATUS has
// write-1-to-clear sticky error bits. The receiver is built only when the
// macro UART_MMIO_RX_EN is defined.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0020,
  parameter int          BAUD_DIV   = 868,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  uart_mmio_if.slave bus,
  output logic       uart_tx,
  input  logic       uart_rx
);
  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam int               FCNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic [3:0]  reg_off;
  logic        tx_wr;
  logic        st_wr;
  logic        rx_rd;
  logic [31:0] status_word;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_rdata;
  logic [FCNT_W-1:0] fifo_count;

  uart_state_e      tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_ovf;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ovr;
  logic       rx_ferr;

  assign bus.Hit = (bus.Address[31:4] == BASE_ADDR[31:4]);
  assign reg_off = {bus.Address[3:2], 2'b00};
  assign tx_wr   = bus.Hit && bus.MemWrite && (reg_off == OFF_TXDATA);
  assign st_wr   = bus.Hit && bus.MemWrite && (reg_off == OFF_STATUS);
  assign rx_rd   = bus.Hit && bus.MemRead && (reg_off == OFF_RXDATA);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .wdata (bus.Write_data[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A new byte is taken when idle or exactly at the end of a stop bit,
  // which makes queued frames contiguous.
  assign fifo_pop = !fifo_empty &&
                    ((tx_state == IDLE) || ((tx_state == STOP) && (tx_cnt == '0)));

  // Transmit FSM with a registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (fifo_pop) begin
            tx_shift <= fifo_rdata;
            tx_cnt   <= BAUD_LAST;
            tx_state <= START;
            uart_tx  <= 1'b0;
          end
        end
        START: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= BAUD_LAST;
            tx_bit   <= '0;
            tx_state <= DATA;
            uart_tx  <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BAUD_LAST;
            if (tx_bit == 3'd7) begin
              tx_state <= STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_W'(1);
          end
        end
        STOP: begin
          if (tx_cnt == '0) begin
            if (fifo_pop) begin
              tx_shift <= fifo_rdata;
              tx_cnt   <= BAUD_LAST;
              tx_state <= START;
              uart_tx  <= 1'b0;
            end else begin
              tx_state <= IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Sticky TX overflow; a dropped store on the same edge beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf <= 1'b0;
    end else if (tx_wr && fifo_full) begin
      tx_ovf <= 1'b1;
    end else if (st_wr && bus.Write_data[ST_TX_OVF]) begin
      tx_ovf <= 1'b0;
    end
  end

`ifdef UART_MMIO_RX_EN
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_DIV / 2 - 1);

  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  uart_state_e      rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receive FSM; clears are written first so a same-edge set overrides them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      if (rx_rd) rx_valid <= 1'b0;
      if (st_wr && bus.Write_data[ST_RX_OVR])  rx_ovr  <= 1'b0;
      if (st_wr && bus.Write_data[ST_RX_FERR]) rx_ferr <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= BAUD_HALF;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= IDLE;
            end else begin
              rx_cnt   <= BAUD_LAST;
              rx_bit   <= '0;
              rx_state <= DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= BAUD_LAST;
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
        STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= IDLE;
            if (!rx_s2) begin
              rx_ferr <= 1'b1;
            end else if (rx_valid && !rx_rd) begin
              rx_ovr <= 1'b1;
            end else begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.Write_data[31:8], bus.Address[1:0], fifo_count};
`else
  assign rx_byte  = '0;
  assign rx_valid = 1'b0;
  assign rx_ovr   = 1'b0;
  assign rx_ferr  = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus.Write_data[31:8], bus.Address[1:0], fifo_count,
                         uart_rx, rx_rd};
`endif

  // STATUS register assembly.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    status_word              = '0;
    status_word[ST_TX_FULL]  = fifo_full;
    status_word[ST_TX_IDLE]  = fifo_empty && (tx_state == IDLE);
    status_word[ST_RX_VALID] = rx_valid;
    status_word[ST_TX_OVF]   = tx_ovf;
    status_word[ST_RX_OVR]   = rx_ovr;
    status_word[ST_RX_FERR]  = rx_ferr;
  end

  // Combinational read mux, answered within the MEM stage.
  always_comb begin
    bus.Read_data = '0;
    if (bus.Hit && bus.MemRead) begin
      case (reg_off)
        OFF_RXDATA: bus.Read_data = {24'b0, rx_byte};
        OFF_STATUS: bus.Read_data = status_word;
        default:    bus.Read_data = '0;
      endcase
    end
  end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral that acts as the responder on the CPU data-memory load/store port. It decodes a small register window next to the data memory and accepts bytes from `sw` into a transmit FIFO, serialising them 8N1 on `uart_tx`. Optionally it receives bytes on `uart_rx` for `lw`. It shares `clk`/`reset` with the pipeline and returns read data combinationally, within the MEM stage, as data memory does.

## Interface
- `BASE_ADDR`, 32'h4000_0020: register window base; decode on `Address[31:4]`.
- `BAUD_DIV`, 868: clocks per bit (100 MHz / 115200); minimum 4.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, at least 2.
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high.
- `MemRead`, input, 1: load in MEM stage.
- `MemWrite`, input, 1: store in MEM stage.
- `Address`, input, 32: byte address from EX_MEM ALU result.
- `Write_data`, input, 32: store data; only bits [7:0] are used.
- `Read_data`, output, 32: load data; 0 when not selected.
- `Hit`, output, 1: `Address` falls in the window; top level muxes `Read_data` with DM on this.
- `uart_tx`, output, 1: serial out; idles high.
- `uart_rx`, input, 1: serial in; asynchronous.

## Operation
- Register map, selected by `Address[3:2]`, with `Address[1:0]` ignored:
  - 0x0 TXDATA: write only; reads 0.
  - 0x4 RXDATA: read only.
  - 0x8 STATUS: read; write-1-to-clear on sticky bits.
  - 0xC: reserved; reads 0, writes ignored.
- STATUS bits:
  - bit0 `tx_full`
  - bit1 `tx_idle` (FIFO empty and FSM IDLE)
  - bit2 `rx_valid`
  - bit3 `tx_ovf` (sticky)
  - bit4 `rx_ovr` (sticky)
  - bit5 `rx_ferr` (sticky)
  - bits [31:6] are 0.
- TXDATA write: push `Write_data[7:0]` when not full. If full, drop the byte and set `tx_ovf`. The full check uses the pre-edge count; a pop on the same edge does not admit the push.
- TX FSM has states IDLE, START, DATA, STOP.
  - IDLE with FIFO non-empty: pop into the shift register, go to START.
  - START and STOP each hold for `BAUD_DIV` clocks.
  - DATA sends 8 bits LSB first, each for `BAUD_DIV` clocks.
  - At the end of STOP: go to START if the FIFO is non-empty (no idle gap), otherwise IDLE.
- RX path:
  - 2-flop synchronizer on `uart_rx`; a falling edge in IDLE starts reception.
  - Recheck the line at `BAUD_DIV/2`. If high, treat as a false start and return to IDLE.
  - Sample 8 data bits at bit centres, then the stop bit.
  - Stop bit 0: discard the byte, set `rx_ferr`.
  - Byte done while `rx_valid` is already 1: keep the old byte, drop the new one, set `rx_ovr`.
- RXDATA read: `Read_data = {24'b0, rx_byte}`. A clock edge with `MemRead` and RXDATA selected clears `rx_valid`. If a new byte completes on the same edge, `rx_valid` stays set with the new byte.
- STATUS write: each 1 in bits [5:3] clears the matching sticky bit. A set event on the same edge wins over the clear.

## Timing
- Reset values:
  - `uart_tx`=1, FIFO empty, FSM IDLE.
  - All status bits 0 except `tx_idle`=1.
  - `Read_data`=0.
  - RX FSM IDLE, synchronizer flops 1.
- `Read_data` and `Hit` are combinational from `Address`/`MemRead`; there is no wait state.
- Store on edge N reaches the FIFO at N. FSM pops at N+1, and `uart_tx` goes low from N+1.
- One frame lasts exactly 10×`BAUD_DIV` clocks. Back-to-back frames are contiguous.
- `reset` mid-frame aborts immediately: `uart_tx` is 1 on the next cycle and FIFO contents are lost.
- The baud counter is `$clog2(BAUD_DIV)` bits wide, counts down, and reloads at each bit boundary.

## Configuration
- `UART_MMIO_RX_EN`:
  - Defined: receiver is built.
  - Undefined: no RX logic; `uart_rx` is present but ignored; RXDATA reads 0; STATUS bits 2, 4 and 5 read 0.

## Structure
- Package `uart_mmio_pkg` holds:
  - register offsets (`OFF_TXDATA`, `OFF_RXDATA`, `OFF_STATUS`);
  - status bit indices;
  - TX/RX state enums (`IDLE`, `START`, `DATA`, `STOP`).
- Sub-module `uart_tx_fifo`: synchronous FIFO with `push`/`pop`/`full`/`empty` and a `$clog2(FIFO_DEPTH)+1`-bit count.
- Top level contains the decode, TX FSM, and RX FSM under the macro.

## Test plan
All scenarios use `BAUD_DIV`=16.
- Single byte: `sw` 0x55 to 0x4000_0020 -> `uart_tx` low at the next edge, then bits 1,0,1,0,1,0,1,0, stop high; 160 clocks total; `tx_idle` back to 1.
- FIFO overflow: 9 consecutive stores of 0x01..0x09 with FSM idle -> first byte popped at once, 0x09 accepted (8 held). A 10th store of 0x0A -> `tx_ovf`=1 and 0x0A never transmitted. Writing STATUS 0x8 clears `tx_ovf`.
- Back-to-back: two stores 0xA5, 0x3C -> 320 contiguous clocks, no high gap between the first stop bit and the second start bit.
- RX (`UART_MMIO_RX_EN`): drive 0xC3 at 16 clocks/bit -> `rx_valid`=1; `lw` 0x4000_0024 returns 0x0000_00C3 and clears `rx_valid`. A second byte arriving before the read -> `rx_ovr`=1 and the old byte is kept.
- Framing error and glitch:
  - Stop bit driven 0 -> `rx_ferr`=1, `rx_valid` stays 0.
  - A 4-clock low glitch -> no reception.
- Reset mid-frame: assert `reset` during DATA -> `uart_tx`=1, STATUS reads 0x2, and the next store transmits normally.
